// File: rtl/d_sync_pkg.sv
// Shared definitions for the bus/enable CDC launcher: FSM encoding and
// hold/gap timer sizing.
package d_sync_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SETUP = 2'd1;
  localparam state_t HOLD  = 2'd2;
  localparam state_t GAP   = 2'd3;

  // Timer counts down from (cycles-1), so it needs enough bits for max-1.
  function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
    int m;
    m = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/d_sync_tx_fifo.sv
// Single-clock input buffer for d_sync_tx; head word is read straight from
// the storage registers and retired by pop.
module d_sync_tx_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/d_sync_tx.sv
// Source-domain launcher for the bus/enable CDC scheme: buffers producer
// words and presents each one as SETUP, HOLD (enable high) and GAP phases.
module d_sync_tx #(
  parameter int BUS_WIDTH   = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUS_WIDTH-1:0]         in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [BUS_WIDTH-1:0]         sync_data,
  output logic                         bus_enable,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  import d_sync_pkg::*;

  localparam int TMR_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);

  state_t               state;
  logic [TMR_W-1:0]     timer;
  logic [BUS_WIDTH-1:0] head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;

  assign in_ready = !fifo_full && !rst;
  assign push     = in_valid && in_ready;
  // A word is launched from IDLE or straight out of the final GAP cycle.
  assign pop      = !fifo_empty && ((state == IDLE) || ((state == GAP) && (timer == '0)));

  d_sync_tx_fifo #(
    .WIDTH (BUS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      sync_data  <= '0;
      bus_enable <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy <= (state != IDLE) || !fifo_empty;
      unique case (state)
        IDLE: begin
          if (pop) begin
            sync_data <= head;
            state     <= SETUP;
          end
        end
        SETUP: begin
          state      <= HOLD;
          bus_enable <= 1'b1;
          timer      <= TMR_W'(HOLD_CYCLES - 1);
        end
        HOLD: begin
          if (timer == '0) begin
            state      <= GAP;
            bus_enable <= 1'b0;
            timer      <= TMR_W'(GAP_CYCLES - 1);
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        GAP: begin
          if (timer == '0) begin
            if (pop) begin
              sync_data <= head;
              state     <= SETUP;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_d_sync_tx.sv
// Bench for d_sync_tx: schedule-based reference model checked every cycle,
// plus directed literal scenarios (single word, back-to-back, full, reset, HOLD=GAP=1).
module tb_d_sync_tx;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int HOLD  = 4;
  localparam int GAP   = 3;
  localparam int PER   = 1 + HOLD + GAP;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] sync_data;
  logic         bus_enable;
  logic         busy;
  logic [2:0]   fifo_count;

  logic [W-1:0] e_data = '0;
  logic         e_valid = 1'b0;
  logic         e_ready;
  logic [W-1:0] e_sync;
  logic         e_en;
  logic         e_busy;
  logic [2:0]   e_count;

  int n_checks = 0;
  int n_pass   = 0;
  int t        = 0;

  // Model state: per accepted word, its accept cycle, SETUP cycle and value.
  int           acc_q[$];
  int           st_q[$];
  logic [W-1:0] dat_q[$];

  d_sync_tx #(.BUS_WIDTH(W), .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sync_data(sync_data), .bus_enable(bus_enable), .busy(busy), .fifo_count(fifo_count)
  );

  d_sync_tx #(.BUS_WIDTH(W), .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(1), .GAP_CYCLES(1)) u_edge (
    .clk(clk), .rst(rst), .in_data(e_data), .in_valid(e_valid), .in_ready(e_ready),
    .sync_data(e_sync), .bus_enable(e_en), .busy(e_busy), .fifo_count(e_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) t <= rst ? 0 : t + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, t, act, exp);
  endtask

  function automatic int m_count(input int c);
    int n = 0;
    foreach (acc_q[k]) if (acc_q[k] < c && st_q[k] - 1 >= c) n++;
    return n;
  endfunction

  function automatic bit m_active(input int c);
    foreach (st_q[k]) if (c >= st_q[k] && c < st_q[k] + PER) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_enable(input int c);
    foreach (st_q[k]) if (c >= st_q[k] + 1 && c <= st_q[k] + HOLD) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] m_data(input int c);
    logic [W-1:0] d = '0;
    foreach (st_q[k]) if (st_q[k] <= c) d = dat_q[k];
    return d;
  endfunction

  always @(negedge clk) begin : model_cmp
    int cnt;
    int s;
    bit exp_busy;
    if (rst) begin
      check("in_ready_in_reset", in_ready, 0);
      acc_q.delete();
      st_q.delete();
      dat_q.delete();
    end else begin
      cnt      = m_count(t);
      exp_busy = (t > 0) && (m_active(t - 1) || m_count(t - 1) != 0);
      check("fifo_count", fifo_count, cnt);
      check("in_ready", in_ready, cnt < DEPTH);
      check("bus_enable", bus_enable, m_enable(t));
      check("sync_data", sync_data, m_data(t));
      check("busy", busy, exp_busy);
      if (in_valid && cnt < DEPTH) begin
        s = t + 2;
        if (st_q.size() > 0 && st_q[$] + PER > s) s = st_q[$] + PER;
        acc_q.push_back(t);
        st_q.push_back(s);
        dat_q.push_back(in_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    e_valid  = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  logic [W-1:0] words [3] = '{8'h11, 8'h22, 8'h33};
  logic         prev_en;
  int           p;

  initial begin
    // Single word: enable on cycles 3..6, busy low from 11.
    do_reset();
    for (int c = 0; c < 13; c++) begin
      in_valid = (c == 0);
      in_data  = 8'hA5;
      mid();
      check("t1_data", sync_data, (c >= 2) ? 8'hA5 : 8'h00);
      check("t1_en", bus_enable, (c >= 3 && c <= 6));
      check("t1_busy", busy, (c >= 2 && c <= 10));
      tick();
    end

    // Back-to-back on both instances; edge instance uses HOLD=GAP=1.
    do_reset();
    prev_en = 1'b0;
    for (int c = 0; c < 29; c++) begin
      in_valid = (c < 3);
      e_valid  = (c < 3);
      if (c < 3) begin
        in_data = words[c];
        e_data  = words[c];
      end
      mid();
      check("t2_rise", bus_enable && !prev_en, (c == 3 || c == 11 || c == 19));
      check("t2_data", sync_data, (c < 2) ? 8'h00 : (c < 10) ? 8'h11 : (c < 18) ? 8'h22 : 8'h33);
      check("edge_en", e_en, (c == 3 || c == 6 || c == 9));
      check("edge_data", e_sync, (c < 2) ? 8'h00 : (c < 5) ? 8'h11 : (c < 8) ? 8'h22 : 8'h33);
      check("edge_busy", e_busy, (c >= 2 && c <= 11));
      if (c == 0) check("edge_ready", e_ready, 1);
      if (c == 1) check("edge_count", e_count, 1);
      prev_en = bus_enable;
      tick();
    end
    e_valid = 1'b0;

    // Full buffer: valid held 8 cycles, five words accepted in order.
    do_reset();
    for (int c = 0; c < 45; c++) begin
      in_valid = (c < 8);
      in_data  = 8'(8'hC0 + c);
      mid();
      if (c == 5) begin
        check("t3_ready_full", in_ready, 0);
        check("t3_count_full", fifo_count, 4);
      end
      if (c == 10) begin
        check("t3_ready_again", in_ready, 1);
        check("t3_count_after", fifo_count, 3);
        check("t3_word1", sync_data, 8'hC1);
      end
      if (c == 34) check("t3_word4", sync_data, 8'hC4);
      if (c == 44) check("t3_no_extra", sync_data, 8'hC4);
      tick();
    end

    // Reset while the first of three words is in HOLD.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      in_valid = (c < 3);
      in_data  = 8'(8'h51 + c);
      mid();
      if (c == 3) check("t4_en_before", bus_enable, 1);
      tick();
    end
    do_reset();
    for (int c = 0; c < 30; c++) begin
      mid();
      if (c == 0) begin
        check("t4_data", sync_data, 8'h00);
        check("t4_count", fifo_count, 0);
        check("t4_busy", busy, 0);
      end
      check("t4_no_en", bus_enable, 0);
      tick();
    end

    // Randomized bursty traffic with occasional resets.
    do_reset();
    p = 50;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        continue;
      end
      if (i % 400 == 0) p = $urandom_range(10, 95);
      in_valid = ($urandom_range(0, 99) < p);
      in_data  = W'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (40) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/d_sync_tx.md
Name: d_sync_tx

Overview:
- Source-domain launcher for the bus/enable multi-bit CDC scheme.
- Buffers words from a valid/ready producer and drives a data bus plus a qualifying enable level toward the destination domain's bus synchronizer.
- Timing is set by fixed cycle counts, with no feedback from the destination:
  - data is stable one cycle before the enable rises;
  - the enable stays high for HOLD_CYCLES;
  - data stays stable through a GAP_CYCLES low period.
- Sits at the transmit boundary of every clock domain crossing that uses the synchronized-enable bus receiver.

Parameters:
- BUS_WIDTH, 8, width of data word.
- FIFO_DEPTH, 4, entries in input buffer; power of two, >=2.
- HOLD_CYCLES, 4, source cycles bus_enable is high; >=1, sized so the destination synchronizer sees the level (>= dest stages x clock ratio).
- GAP_CYCLES, 3, source cycles bus_enable is low after HOLD while sync_data stays stable; >=1.

Ports:
- clk  in  1  source clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  BUS_WIDTH  word from producer.
- in_valid  in  1  producer has a word.
- in_ready  out  1  buffer can accept; combinational = (count < FIFO_DEPTH) && !rst.
- sync_data  out  BUS_WIDTH  registered bus to destination.
- bus_enable  out  1  registered qualifying level to destination.
- busy  out  1  registered; high when the FSM is not IDLE or count != 0.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current buffer occupancy.

Behaviour:
- Reset is synchronous, sampled on posedge clk while rst=1:
  - sync_data=0, bus_enable=0, busy=0;
  - FIFO pointers and count=0;
  - FSM=IDLE, counters=0.
- Reset mid-transfer aborts the word. bus_enable is low the cycle after reset is sampled, and buffered words are discarded.
- Push occurs when in_valid && in_ready.
  - No push when full, even if a pop happens the same cycle.
  - A simultaneous push and pop when not full leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states are IDLE, SETUP, HOLD and GAP.
- IDLE:
  - If count>0: pop the head, register it into sync_data, go to SETUP.
  - Otherwise stay; sync_data keeps its last value.
- SETUP, 1 cycle: bus_enable=0, sync_data is stable. Next state HOLD, with bus_enable registered to 1 and the counter loaded.
- HOLD: bus_enable=1 for exactly HOLD_CYCLES cycles, then GAP with bus_enable registered to 0.
- GAP: bus_enable=0 for exactly GAP_CYCLES cycles.
  - On the last GAP cycle, if count>0: pop, load sync_data, go to SETUP (back-to-back).
  - Otherwise go to IDLE.
- sync_data changes only on the transition into SETUP. It never changes while bus_enable=1 or during GAP.
- Latency: word accepted at cycle N.
  - Popped at N+1.
  - sync_data valid from N+2 (SETUP).
  - bus_enable high from N+3 through N+2+HOLD_CYCLES.
- Throughput is one word per 1+HOLD_CYCLES+GAP_CYCLES cycles. bus_enable rising edges are exactly that far apart when back-to-back.
- bus_enable has exactly one rising edge per word and is glitch-free, because it is driven directly from a flop.
- busy goes low the cycle after the FSM returns to IDLE with count=0.

Decomposition:
- Shared package d_sync_pkg holds:
  - the FSM state encoding constants (IDLE, SETUP, HOLD, GAP; 2-bit);
  - a counter-width function based on max(HOLD_CYCLES, GAP_CYCLES).
- One sub-module: d_sync_tx_fifo.
  - Synchronous single-clock FIFO with push/pop/count, synchronous active-high reset.
  - Registered head read via pop.
- The top level contains the FSM, the hold/gap counter, and the output registers.

Test Plan:
1. Single word: HOLD=4, GAP=3; push 0xA5 at cycle 0.
   -> sync_data=0xA5 from cycle 2; bus_enable=1 on cycles 3-6, 0 from 7; busy low from cycle 11.
2. Back-to-back: push 0x11, 0x22, 0x33 on cycles 0-2.
   -> bus_enable rises at cycles 3, 11, 19.
   -> sync_data changes only at cycles 10 and 18, never while bus_enable=1 or in GAP.
3. Full buffer: FIFO_DEPTH=4; hold in_valid=1 for 8 cycles from cycle 0.
   -> in_ready drops once count=4; no word is lost or duplicated; all accepted words appear in order.
4. Reset mid-HOLD: 2 words buffered; assert rst for 1 cycle while bus_enable=1.
   -> next cycle bus_enable=0, sync_data=0, fifo_count=0, busy=0; no further enable edges.
5. Loopback: connect to the destination bus synchronizer at a destination clock 2.5x slower, with HOLD sized accordingly; send 16 random words.
   -> the destination receives all 16 in order, each with exactly one enable pulse.
6. Parameter edge: HOLD=1, GAP=1.
   -> bus_enable is a 1-cycle high every 3 cycles back-to-back; data is stable from SETUP through GAP.
